// File: rtl/uart_serial_rx_pkg.sv
// uart_serial_rx_pkg: UART bit-timing helper shared with uart_tx, RX state encodings
// and the bit order of the MMIO status word.
package uart_serial_rx_pkg;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam int STAT_NEW_DATA    = 0;
    localparam int STAT_OVERRUN     = 1;
    localparam int STAT_FRAME_ERROR = 2;
    function automatic int clks_per_bit(input int clk_mhz, input int baud);
        return (clk_mhz * 1_000_000) / baud;
    endfunction
endpackage

// File: rtl/uart_serial_rx_sync_2ff.sv
// uart_serial_rx_sync_2ff: two-flop synchroniser for one asynchronous input, with a
// selectable reset value so idle-high lines come out of reset idle.
module uart_serial_rx_sync_2ff #(
    parameter logic RstVal = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RstVal;
            sync_q <= RstVal;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/uart_serial_rx.sv
// uart_serial_rx: 8N1 UART receiver with 3-sample majority voting, a held output byte
// and sticky new-data/overrun status for the MMIO mapper.
module uart_serial_rx import uart_serial_rx_pkg::*; #(
    parameter int BaudRate       = 115200,
    parameter int ClockSpeed_MHz = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_serial,
    input  logic       in_data_is_read,
    output logic [7:0] out_data,
    output logic       out_data_valid,
    output logic       out_new_data,
    output logic       out_overrun,
    output logic       out_frame_error
);
    localparam int ClksPerBit = clks_per_bit(ClockSpeed_MHz, BaudRate);
    localparam int HalfBit    = ClksPerBit / 2;
    localparam int CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntMax  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntS0   = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] CntS1   = CntW'(HalfBit);
    localparam logic [CntW-1:0] CntDec  = CntW'(HalfBit + 1);

    if (ClksPerBit < 8) begin : g_bad_rate
        $error("uart_serial_rx: ClksPerBit must be >= 8");
    end

    logic rx_s;
    uart_serial_rx_sync_2ff #(.RstVal(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_serial),
        .q   (rx_s)
    );

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      sr_q, sr_d;
    logic [1:0]      samp_q, samp_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            new_q, new_d;
    logic            ovr_q, ovr_d;
    logic            decide, bit_v;

    assign decide = (cnt_q == CntDec);
    assign bit_v  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // Line-high after reset or a break is confirmed by a full majority decision, so the
    // synchroniser's idle reset value cannot open a frame on a line that is really low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        sr_d      = sr_q;
        samp_d    = samp_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        if (cnt_q == CntS0) samp_d[0] = rx_s;
        if (cnt_q == CntS1) samp_d[1] = rx_s;
        case (state_q)
            ST_WAIT_HIGH: if (decide && bit_v) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (decide) begin
                    state_d   = bit_v ? ST_IDLE : ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    sr_d[bit_idx_q] = bit_v;
                    bit_idx_d       = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    data_d  = bit_v ? sr_q : data_q;
                    valid_d = bit_v;
                    ferr_d  = !bit_v;
                    state_d = bit_v ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            default: state_d = ST_WAIT_HIGH;
        endcase
    end

    always_comb begin
        new_d = new_q;
        ovr_d = ovr_q;
        if (valid_q) begin
            new_d = 1'b1;
            ovr_d = ovr_q | (new_q & !in_data_is_read);
        end else if (in_data_is_read) begin
            new_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_HIGH;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            sr_q      <= '0;
            samp_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            sr_q      <= sr_d;
            samp_q    <= samp_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            new_q <= new_d;
            ovr_q <= ovr_d;
        end
    end

    assign out_data        = data_q;
    assign out_data_valid  = valid_q;
    assign out_frame_error = ferr_q;
    assign out_new_data    = new_q;
    assign out_overrun     = ovr_q;
endmodule
